// File: rtl/divider_unit.sv
// -----------------------------------------------------------------------------
// divider_unit
//
// Multi-cycle radix-2 restoring integer divider for a 32-bit core. Handles
// DIVU/REMU (signed_op=0) and DIV/REM (signed_op=1) semantics, including the
// divide-by-zero and most-negative / -1 overflow results.
//
// Latency: if start is sampled at edge k, done is high in the cycle after
// edge k+33. That is one setup edge, 32 CALC steps and one FIX step.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   request a divide; ignored while busy
//   signed_op  in   1 = signed divide, 0 = unsigned; sampled with start
//   numer      in   dividend, sampled with start
//   denom      in   divisor, sampled with start
//   quotient   out  registered quotient; holds until the next result
//   remain     out  registered remainder; holds until the next result
//   busy       out  high in CALC and FIX
//   done       out  one-cycle pulse; quotient/remain are valid in that cycle
//
// Build option
//   DIV_EARLY_OUT_EN  When defined, divide-by-zero and signed overflow finish
//                     at the start edge. The FSM goes straight to DONE and busy
//                     stays low. When undefined, these cases take the full
//                     latency and FIX forces their results.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start
// CALC  | one restoring step per cycle, 32 cycles
// FIX   | sign correction / special-case override, result written
// DONE  | done pulse; start here launches the next op directly
// -----------------------------------------------------------------------------
module divider_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            signed_op,
  input  logic [XLEN-1:0] numer,
  input  logic [XLEN-1:0] denom,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remain,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  localparam logic [5:0]      LAST_ITER = 6'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONES  = '1;
  localparam logic [XLEN-1:0] ONE       = XLEN'(1);

  state_t          state_q;
  logic [5:0]      cnt_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] div_q;
  logic [XLEN-1:0] numer_q;
  logic            neg_n_q;
  logic            neg_d_q;
  logic            sop_q;
  logic [XLEN-1:0] quot_out_q;
  logic [XLEN-1:0] rem_out_q;
  logic            busy_q;
  logic            done_q;

  // Operand conditioning. The two's-complement negate of MIN_NEG wraps back
  // to MIN_NEG. Read as unsigned, that is the correct magnitude.
  logic            numer_neg;
  logic            denom_neg;
  logic [XLEN-1:0] numer_abs;
  logic [XLEN-1:0] denom_abs;

  always_comb begin
    numer_neg = signed_op & numer[XLEN-1];
    denom_neg = signed_op & denom[XLEN-1];
    numer_abs = numer_neg ? (~numer + ONE) : numer;
    denom_abs = denom_neg ? (~denom + ONE) : denom;
  end

  // One restoring step. The partial remainder is shifted left with the next
  // dividend bit, which can make it XLEN+1 bits wide. It is compared against
  // the divisor at full width. A kept difference is always below the divisor,
  // so it fits back into XLEN bits.
  logic [XLEN:0]   shifted;
  logic            take;
  logic [XLEN-1:0] rem_d;
  logic [XLEN-1:0] quo_d;

  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    take    = (shifted >= {1'b0, div_q});
    rem_d   = take ? XLEN'(shifted - {1'b0, div_q}) : shifted[XLEN-1:0];
    quo_d   = {quo_q[XLEN-2:0], take};
  end

  // Final correction. Special cases override the sign-corrected values.
  // div_q==0 is exactly denom==0. A divisor magnitude of 1 with the divisor
  // sign set is exactly denom==-1 in signed mode.
  logic [XLEN-1:0] quot_fix_d;
  logic [XLEN-1:0] rem_fix_d;

  always_comb begin
    quot_fix_d = (neg_n_q ^ neg_d_q) ? (~quo_q + ONE) : quo_q;
    rem_fix_d  = neg_n_q ? (~rem_q + ONE) : rem_q;
    if (div_q == '0) begin
      quot_fix_d = ALL_ONES;
      rem_fix_d  = numer_q;
    end else if (sop_q && neg_d_q && (numer_q == MIN_NEG) && (div_q == ONE)) begin
      quot_fix_d = MIN_NEG;
      rem_fix_d  = '0;
    end
  end

  logic            early_out;
  logic [XLEN-1:0] early_quot;
  logic [XLEN-1:0] early_rem;

`ifdef DIV_EARLY_OUT_EN
  always_comb begin
    early_out  = 1'b0;
    early_quot = '0;
    early_rem  = '0;
    if (denom == '0) begin
      early_out  = 1'b1;
      early_quot = ALL_ONES;
      early_rem  = numer;
    end else if (signed_op && (numer == MIN_NEG) && (denom == ALL_ONES)) begin
      early_out  = 1'b1;
      early_quot = MIN_NEG;
      early_rem  = '0;
    end
  end
`else
  assign early_out  = 1'b0;
  assign early_quot = '0;
  assign early_rem  = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      div_q      <= '0;
      numer_q    <= '0;
      neg_n_q    <= 1'b0;
      neg_d_q    <= 1'b0;
      sop_q      <= 1'b0;
      quot_out_q <= '0;
      rem_out_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          if (start) begin
            rem_q   <= '0;
            quo_q   <= numer_abs;
            div_q   <= denom_abs;
            numer_q <= numer;
            neg_n_q <= numer_neg;
            neg_d_q <= denom_neg;
            sop_q   <= signed_op;
            cnt_q   <= '0;
            if (early_out) begin
              quot_out_q <= early_quot;
              rem_out_q  <= early_rem;
              state_q    <= S_DONE;
              done_q     <= 1'b1;
            end else begin
              state_q <= S_CALC;
              busy_q  <= 1'b1;
            end
          end
        end
        S_CALC: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == LAST_ITER) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          quot_out_q <= quot_fix_d;
          rem_out_q  <= rem_fix_d;
          busy_q     <= 1'b0;
          done_q     <= 1'b1;
          state_q    <= S_DONE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign quotient = quot_out_q;
  assign remain   = rem_out_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_divider_unit.sv
`timescale 1ns/1ps
// Scoreboard bench for divider_unit. The driver pushes the hand-computed
// result and its latency when it issues an op. The monitor pops and compares
// on every done pulse. Latency is counted from the cycle in which start is
// presented: 34 for a full op, 1 for an early-out op.
module tb_divider_unit;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        start     = 1'b0;
  logic        signed_op = 1'b0;
  logic [31:0] numer     = '0;
  logic [31:0] denom     = '0;
  logic [31:0] quotient;
  logic [31:0] remain;
  logic        busy;
  logic        done;

  divider_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .signed_op (signed_op),
    .numer     (numer),
    .denom     (denom),
    .quotient  (quotient),
    .remain    (remain),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  localparam int LAT = 34;
`ifdef DIV_EARLY_OUT_EN
  localparam int LAT_SP = 1;
`else
  localparam int LAT_SP = 34;
`endif

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          issued;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 q=0x%08h r=0x%08h, expected no pulse",
                 quotient, remain);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.name, "_quot"}, quotient, mon_e.q);
        check({mon_e.name, "_rem"},  remain,   mon_e.r);
        check({mon_e.name, "_lat"},  32'(cyc - mon_e.issued), 32'(mon_e.lat));
      end
    end
  end

  // Present start for one cycle (called at negedge+1), record the expectation,
  // then check busy once the start edge has passed.
  task automatic issue(input string name, input logic sop, input logic [31:0] n,
                       input logic [31:0] d, input logic [31:0] q, input logic [31:0] r,
                       input int lat);
    exp_t e;
    signed_op = sop;
    numer     = n;
    denom     = d;
    start     = 1'b1;
    e.q = q; e.r = r; e.issued = cyc; e.lat = lat; e.name = name;
    sb.push_back(e);
    step();
    start = 1'b0;
    check({name, "_busy"}, {31'b0, busy}, (lat == 1) ? 32'd0 : 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      step();
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
      sb.delete();
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200us, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int dc;

    repeat (3) step();
    check("rst_quot", quotient, 32'h0);
    check("rst_rem",  remain,   32'h0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);

    // First start is accepted on the first edge after reset release.
    rst_n = 1'b1;
    issue("udiv_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, LAT);
    drain();

    issue("sdiv_m7_2",  1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, LAT); drain();
    issue("sdiv_7_m2",  1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        LAT); drain();
    issue("sdiv_m7_m2", 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, LAT); drain();
    issue("udiv_max_16",1'b0, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 32'hF,        LAT); drain();
    issue("udiv_big",   1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1,        32'd1,        LAT); drain();
    issue("sdiv_min_2", 1'b1, 32'h80000000, 32'd2,        32'hC0000000, 32'd0,        LAT); drain();

    // Quotient/remainder hold after completion.
    repeat (5) step();
    check("hold_quot", quotient, 32'hC0000000);

    // Divide by zero and overflow.
    issue("sdiv0",      1'b1, 32'h80000005, 32'd0,        32'hFFFFFFFF, 32'h80000005, LAT_SP); drain();
    issue("udiv0",      1'b0, 32'h80000005, 32'd0,        32'hFFFFFFFF, 32'h80000005, LAT_SP); drain();
    issue("sdiv0_pos",  1'b1, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        LAT_SP); drain();
    issue("sovf",       1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        LAT_SP); drain();
    issue("uovf",       1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, LAT);    drain();

    // A start pulse during an op is ignored.
    issue("ign_base", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, LAT);
    repeat (9) step();
    check("ign_busy", {31'b0, busy}, 32'd1);
    signed_op = 1'b1; numer = 32'd5; denom = 32'd1; start = 1'b1;
    step();
    start = 1'b0;
    drain();

    // Back-to-back: start presented in the DONE cycle.
    issue("b2b_a", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, LAT);
    n = 0;
    while (!done && n < 60) begin
      step();
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL b2b_wait: got done=0 after %0d cycles, expected a pulse", n);
    end
    issue("b2b_b", 1'b0, 32'd81, 32'd9, 32'd9, 32'd0, LAT);
    drain();

    // Reset mid-operation aborts without a done pulse.
    issue("abort", 1'b0, 32'h12345678, 32'd3, 32'h06117228, 32'd0, LAT);
    repeat (15) step();
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_quot", quotient, 32'h0);
    check("abort_rem",  remain,   32'h0);
    dc = done_cnt;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (40) step();
    check("abort_no_done", 32'(done_cnt), 32'(dc));
    check("abort_hold_quot", quotient, 32'h0);
    issue("post_abort", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, LAT);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/divider_unit.md
DIVIDER_UNIT -- requirements
Module: divider_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand width; only 32 supported.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request a divide; sampled on clk rising edge.
REQ-005 SHALL have port signed_op  input  1  1 = DIV/REM semantics, 0 = DIVU/REMU; sampled with start.
REQ-006 SHALL have port numer  input  32  dividend; sampled with start.
REQ-007 SHALL have port denom  input  32  divisor; sampled with start.
REQ-008 SHALL have port quotient  output  32  registered quotient result.
REQ-009 SHALL have port remain  output  32  registered remainder result.
REQ-010 SHALL have port busy  output  1  high while an operation is in progress; ALU holds divide_stall from it.
REQ-011 SHALL have port done  output  1  single-cycle pulse; quotient/remain valid in that cycle.

Function
REQ-012 SHALL implement an FSM with states IDLE, CALC, FIX and DONE.
REQ-013 IDLE or DONE with start=1 SHALL latch |numer|, |denom| (absolute value only when signed_op=1), both sign bits and signed_op, clear a 6-bit iteration counter, and enter CALC.
REQ-014 start SHALL be ignored while busy=1; operands then unchanged.
REQ-015 CALC SHALL perform one radix-2 restoring step per cycle: shift {rem,quo} left by 1, subtract divisor, and keep the result plus quotient bit 1 when the difference is non-negative.
REQ-016 CALC SHALL last exactly 32 cycles, then enter FIX.
REQ-017 FIX SHALL apply signed corrections: quotient negated when the operand signs differ, and remainder takes the dividend sign.
REQ-018 FIX SHALL write quotient/remain and enter DONE.
REQ-019 DONE SHALL assert done for one cycle, then return to IDLE unless start=1 (per REQ-013).
REQ-020 busy SHALL be 1 in CALC and FIX, and 0 in IDLE and DONE.
REQ-021 Latency SHALL be fixed: start sampled at edge k gives done=1 in the cycle following edge k+33.
REQ-022 quotient/remain SHALL hold their last values until the next FIX (or early-out) update.
REQ-023 When denom==0 (signed or unsigned), quotient SHALL be 0xFFFFFFFF and remain SHALL be numer; this is independent of the sign correction.
REQ-024 When signed_op=1, numer=0x80000000 and denom=0xFFFFFFFF, quotient SHALL be 0x80000000 and remain SHALL be 0.
REQ-025 Absolute value of 0x80000000 SHALL be treated as unsigned 0x80000000 (no overflow).

Reset
REQ-026 While rst_n=0, state SHALL be IDLE, and quotient, remain, busy, done and the counter SHALL all be 0.
REQ-027 Reset asserted mid-operation SHALL abort it immediately, with no done pulse afterward.
REQ-028 The first start after rst_n deasserts SHALL be accepted on the first rising edge.

Configuration
REQ-029 Macro DIV_EARLY_OUT_EN SHALL control the early-out feature.
REQ-030 With DIV_EARLY_OUT_EN defined, divide-by-zero and signed overflow (REQ-023/024) SHALL skip CALC/FIX: results load at the start edge k, the FSM goes directly to DONE, and done=1 in the cycle after edge k.
REQ-031 With DIV_EARLY_OUT_EN defined, busy SHALL remain 0 for early-out operations.
REQ-032 Without DIV_EARLY_OUT_EN, all operations SHALL take the REQ-021 latency; special-case values SHALL still be produced, forced in FIX.

Verification
REQ-033 Unsigned basic: numer=100, denom=7, signed_op=0 -> quotient=14, remain=2, done exactly 34 cycles after start.
REQ-034 Signed mixed: numer=-7 (0xFFFFFFF9), denom=2, signed_op=1 -> quotient=0xFFFFFFFD (-3), remain=0xFFFFFFFF (-1).
REQ-035 Divide by zero: numer=0x80000005, denom=0, for both signed_op values -> quotient=0xFFFFFFFF, remain=0x80000005; latency 1 with DIV_EARLY_OUT_EN, 34 without.
REQ-036 Overflow: numer=0x80000000, denom=0xFFFFFFFF, signed_op=1 -> quotient=0x80000000, remain=0; the same inputs with signed_op=0 -> quotient=0, remain=0x80000000.
REQ-037 Protocol: start pulsed at cycle 10 of an operation is ignored (result unchanged); start held in the DONE cycle launches a back-to-back op with no IDLE cycle.
REQ-038 Reset abort: rst_n driven low at CALC iteration 15 -> busy=0, done never pulses, quotient=remain=0; next start completes normally.
